datamemory_lanes: RTL and testbench

DATAMEMORY_LANES -- requirements
Module: datamemory_lanes

---
 rtl/datamemory_lanes.sv | 172 +++++++++++++++++
 tb/tb_datamemory_lanes.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamemory_lanes.sv
// Byte-lane data memory that zero-fills itself after reset, followed by a LATENCY-deep response pipeline.
// Define DATAMEMORY_LANES_MISALIGN_TRAP_EN to trap misaligned accesses. Without it, misaligned offsets are forced down to an aligned lane.
//
// state   | meaning
// --------+----------------------------------------------------
// ST_INIT | zero one word per cycle, requests blocked
// ST_RUN  | clearing finished, one request accepted per cycle

module datamemory_lanes #(
    parameter int ADDRWIDTH = 32,
    parameter int DEPTH     = 1024,
    parameter int WIDTH     = 32,
    parameter int LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 rsp_valid,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 rsp_error,
    output logic                 init_done
);

    localparam int BYTES = WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);
    localparam logic [OFFW:0]   ONE_N   = 1;
    localparam logic [OFFW-1:0] ONE_OFF = 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   clr_cnt_q, clr_cnt_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              mem_we;
    logic [IDXW-1:0]   mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [LATENCY-1:0] pipe_err_q, pipe_err_d;
    logic [WIDTH-1:0]   pipe_data_q [LATENCY];
    logic [WIDTH-1:0]   pipe_data_d [LATENCY];

    logic              accept;
    logic [IDXW-1:0]   word_idx;
    logic [OFFW-1:0]   lane_off, size_mask, off_eff;
    logic [1:0]        eff_size;
    logic [OFFW:0]     nbytes;
    logic              trap;
    logic [BYTES-1:0]  be;
    logic [WIDTH-1:0]  rd_word, rd_shift, wdata_sh, merged, load_ext;
    logic              sign_bit;

    assign req_ready = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[OFFW +: IDXW];
    assign lane_off  = req_addr[OFFW-1:0];
    assign rd_word   = mem_q[word_idx];

    generate
        if (ADDRWIDTH > OFFW + IDXW) begin : g_addr_hi
            // Upper address bits wrap away, so they are deliberately ignored.
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDRWIDTH-1:OFFW+IDXW];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_INIT) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDXW'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        eff_size  = (req_size > 2'(OFFW)) ? 2'(OFFW) : req_size;
        nbytes    = ONE_N << eff_size;
        size_mask = nbytes[OFFW-1:0] - ONE_OFF;
`ifdef DATAMEMORY_LANES_MISALIGN_TRAP_EN
        trap    = (req_size > 2'(OFFW)) || ((lane_off & size_mask) != '0);
        off_eff = lane_off;
`else
        trap    = 1'b0;
        off_eff = lane_off & ~size_mask;
`endif
        for (int b = 0; b < BYTES; b++) begin
            be[b] = (b >= int'(off_eff)) && (b < int'(off_eff) + int'(nbytes));
        end
        wdata_sh = req_wdata << {off_eff, 3'b000};
        for (int b = 0; b < BYTES; b++) begin
            merged[8*b +: 8] = be[b] ? wdata_sh[8*b +: 8] : rd_word[8*b +: 8];
        end
        rd_shift = rd_word >> {off_eff, 3'b000};
        case (eff_size)
            2'd0:    sign_bit = rd_shift[7];
            2'd1:    sign_bit = rd_shift[15];
            2'd2:    sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[WIDTH-1];
        endcase
        for (int i = 0; i < WIDTH; i++) begin
            load_ext[i] = (i < 8 * int'(nbytes)) ? rd_shift[i] : (sign_bit & ~req_unsigned);
        end
    end

    // Clearing owns the write port during INIT; requests cannot be accepted then.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = word_idx;
        mem_wdata = merged;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end else if (accept && req_write && !trap) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        pipe_vld_d[0]  = accept;
        pipe_err_d[0]  = accept && trap;
        pipe_data_d[0] = (accept && !req_write && !trap) ? load_ext : '0;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_err_d[i]  = pipe_err_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            clr_cnt_q  <= '0;
            pipe_vld_q <= '0;
            pipe_err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_err_q <= pipe_err_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rsp_valid = pipe_vld_q[LATENCY-1];
    assign rsp_rdata = pipe_data_q[LATENCY-1];
    assign rsp_error = pipe_err_q[LATENCY-1];

endmodule

// File: tb/tb_datamemory_lanes.sv
// Scoreboard bench for datamemory_lanes: DEPTH=16, WIDTH=32, LATENCY=3.
// The expectations follow DATAMEMORY_LANES_MISALIGN_TRAP_EN when it is defined.

module tb_datamemory_lanes;

    localparam int AW  = 32;
    localparam int DEP = 16;
    localparam int W   = 32;
    localparam int LAT = 3;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          rsp_valid;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_error;
    logic          init_done;

    int checks   = 0;
    int failures = 0;
    int ncyc     = 0;

    logic [32:0] exp_q [$];
    int          acc_q [$];
    logic [31:0] model_mem [DEP];

    datamemory_lanes #(.ADDRWIDTH(AW), .DEPTH(DEP), .WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .init_done(init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Byte-level reference model of a single access.
    function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err);
        int n   = 1 << sz;
        int off = int'(addr[1:0]);
        int idx = int'(addr[5:2]);
        rd  = 32'h0;
        err = 1'b0;
`ifdef DATAMEMORY_LANES_MISALIGN_TRAP_EN
        if (sz == 2'd3 || (off % n) != 0) begin
            err = 1'b1;
            return;
        end
`else
        if (sz == 2'd3) n = 4;
        off = off - (off % n);
`endif
        if (wr) begin
            for (int k = 0; k < n; k++) model_mem[idx][8*(off+k) +: 8] = wd[8*k +: 8];
        end else begin
            for (int k = 0; k < n; k++) rd[8*k +: 8] = model_mem[idx][8*(off+k) +: 8];
            if (!uns && rd[8*n-1]) begin
                for (int k = n; k < 4; k++) rd[8*k +: 8] = 8'hFF;
            end
        end
    endfunction

    // Responses are matched in order; acceptance cycles give the latency.
    always @(negedge clk) begin
        logic [32:0] e;
        int a;
        ncyc++;
        if (reset_n && req_valid && req_ready) acc_q.push_back(ncyc);
        if (rsp_valid) begin
            checks++;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h at cycle %0d, required no response", rsp_rdata, ncyc);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                if (rsp_rdata !== e[31:0]) begin
                    failures++;
                    $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, e[31:0]);
                end
                checks++;
                if (rsp_error !== e[32]) begin
                    failures++;
                    $display("FAIL rsp_error: got %b, required %b", rsp_error, e[32]);
                end
                checks++;
                if (ncyc - a !== LAT) begin
                    failures++;
                    $display("FAIL rsp_latency: got %0d, required %0d", ncyc - a, LAT);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] rd_unused;
        logic        er_unused;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        model(wr, sz, uns, addr, wd, rd_unused, er_unused);
        exp_q.push_back({exp_e, exp_d});
    endtask

    task automatic drain();
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic assert_reset();
        @(posedge clk); #1;
        reset_n = 1'b0; req_valid = 1'b0;
        exp_q.delete();
        acc_q.delete();
        for (int i = 0; i < DEP; i++) model_mem[i] = 32'h0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({req_ready, init_done, rsp_valid, rsp_error, rsp_rdata} !== 36'h0) begin
                failures++;
                $display("FAIL reset_outputs: ready=%b done=%b vld=%b err=%b rdata=%h, required all 0",
                         req_ready, init_done, rsp_valid, rsp_error, rsp_rdata);
            end
        end
    endtask

    task automatic release_and_count();
        int k;
        logic ready_early;
        ready_early = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == DEP - 1) ready_early = req_ready | init_done;
            if (init_done) break;
        end
        checks++;
        if (k !== DEP) begin
            failures++;
            $display("FAIL init_cycles: init_done after %0d cycles, required %0d", k, DEP);
        end
        checks++;
        if (ready_early !== 1'b0) begin
            failures++;
            $display("FAIL init_ready_early: ready|done=%b one cycle before end, required 0", ready_early);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        assert_reset();
        release_and_count();
    endtask

    task automatic test_init_zero();
        issue(1'b0, 2'd2, 1'b0, 32'h0,  32'h0, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    task automatic test_lanes();
        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h9, 32'h0000007F, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'hDEAD7FEF, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'hB, 32'h0, 32'hFFFFFFDE, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 32'h0000DEAD, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 32'hFFFFDEAD, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 32'h0000007F, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, 32'h000000EF, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h8, 32'h0, 32'hFFFFFFEF, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, 32'h00007FEF, 1'b0);
        drain();
    endtask

    task automatic test_misalign();
        issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h11223344, 32'h0, 1'b0);
`ifdef DATAMEMORY_LANES_MISALIGN_TRAP_EN
        issue(1'b1, 2'd1, 1'b0, 32'h5, 32'h0000AABB, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h11223344, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h7, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b1, 32'h6, 32'h0, 32'h0, 1'b1);
`else
        issue(1'b1, 2'd1, 1'b0, 32'h5, 32'h0000AABB, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h1122AABB, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h7, 32'h0, 32'h00001122, 1'b0);
        issue(1'b0, 2'd2, 1'b1, 32'h6, 32'h0, 32'h1122AABB, 1'b0);
`endif
        drain();
    endtask

    task automatic test_wrap();
        issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h0,  32'h0, 32'hCAFEF00D, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h7D, 32'h00000055, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h3D, 32'h0, 32'h00000055, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic        wr, uns, er;
        logic [1:0]  sz;
        logic [31:0] addr, wd, rd;
        for (int i = 0; i < 48; i++) begin
            wr   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 2));
            addr = 32'($urandom_range(0, 127));
            wd   = $urandom;
            model(wr, sz, uns, addr, wd, rd, er);
            issue(wr, sz, uns, addr, wd, rd, er);
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        assert_reset();
        release_and_count();
        repeat (2 * LAT) @(negedge clk);
    endtask

    task automatic test_reset_midinit();
        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h12345678, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h3C, 32'h87654321, 32'h0, 1'b0);
        drain();
        assert_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        assert_reset();
        release_and_count();
        issue(1'b0, 2'd2, 1'b0, 32'h8,  32'h0, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
        drain();
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_init_zero();
        test_lanes();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_inflight();
        test_reset_midinit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
